multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle RV32I control unit: a state machine that sequences each instruction over 3–5 cycles through a shared ALU, a unified memory port and the instruction/ALUOut/data registers of the multicycle datapath. It adds the full conditional-branch set, LUI/AUIPC/JALR, memory wait-state handshaking with timeout, and a retired-instruction counter. It sits beside the multicycle datapath and replaces the single-cycle controller in that build.

## Interface
- CNT_W, 32: width of instret counter.
- WAIT_LIMIT, 16: memory wait cycles tolerated before bus error; 0 disables timeout.

- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op  in  7  instruction opcode (from instruction register).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed rs1 < rs2.
- LtU  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request (read unless MemWrite).
- MemWrite  out  1  store strobe, valid with mem_req.
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address.
- IRWrite  out  1  load instruction and OldPC registers.
- PCWrite  out  1  load PC from result bus.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- state  out  4  current state encoding (debug).
- instret  out  CNT_W  retired instruction count.
- bus_err  out  1  sticky: memory timeout occurred.
- illegal  out  1  sticky: illegal opcode trapped.

## Operation
- States and encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE.
  - 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR, 12 UTYPE, 13 HALT.
- Outputs not listed for a state are 0; ALUControl defaults to add.
- FETCH: mem_req=1, AdrSrc=0. Hold until mem_ready. On the mem_ready cycle: IRWrite=1, PCWrite=1, A=00, B=10, ResultSrc=10; next state DECODE.
- DECODE: A=01, B=01, ImmSrc=011 if op=1101111 else 010 (ALUOut = branch/jump target).
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111/0010111 → UTYPE.
  - Any other op: see Configuration.
- MEMADR: A=10, B=01, ImmSrc I for load, S for store. Next state MEMREAD (op[5]=0) or MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; next state FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Hold until mem_ready, then FETCH.
- EXECR: A=10, B=00. EXECI: A=10, B=01, ImmSrc I. Both go to ALUWB.
  - funct3 → ALUControl: 000 add (sub if EXECR and funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if funct7b5), 110 or, 111 and.
- ALUWB: ResultSrc=00, RegWrite=1; next state FETCH.
- BRANCH: A=10, B=00, sub, ResultSrc=00. PCWrite=take; next state FETCH.
  - take: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 LtU, 111 !LtU; 010/011 never taken.
- JALR: A=10, B=01, ImmSrc I, add; next state JAL.
- JAL: PCWrite=1, ResultSrc=00, A=01, B=10; next state ALUWB (rd = OldPC+4).
- UTYPE: A=11 (lui) or 01 (auipc), B=01, ImmSrc U; next state ALUWB.
- HALT: all strobes 0; stays in HALT until reset.
- instret increments on every transition into FETCH from a state other than FETCH and HALT; wraps modulo 2^CNT_W.
- Timeout:
  - wait_cnt counts consecutive mem_ready=0 cycles in FETCH/MEMREAD/MEMWRITE and clears whenever the state changes.
  - If WAIT_LIMIT≠0 and wait_cnt==WAIT_LIMIT-1 with mem_ready=0: next state HALT and bus_err set.
  - mem_ready on that same cycle wins over timeout.

## Timing
- Outputs are combinational from state plus inputs. FETCH/MEMREAD/MEMWRITE strobes are gated by mem_ready.
- Zero-wait latencies: R/I/U-type 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5.
- Reset: while reset_n=0, PCWrite/IRWrite/RegWrite/MemWrite/mem_req are forced 0. On the next edge: state=FETCH, instret=0, wait_cnt=0, bus_err=0, illegal=0.
- Reset mid-instruction abandons the instruction without retiring it.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unknown opcode in DECODE moves to HALT and sets illegal.
- Not defined: an unknown opcode goes DECODE → FETCH as a NOP, with no write strobes and no instret increment. The illegal output is tied to 0.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 → states 0,1,6,8,0; ALUControl 0000 in EXECR; RegWrite=1 in ALUWB; instret 0→1.
- lw with mem_ready low 3 cycles in MEMREAD, WAIT_LIMIT=16 → MEMREAD held 4 cycles; mem_req/AdrSrc=1 throughout; MEMWB RegWrite=1, ResultSrc=01.
- bge (f3 101) with Lt=1 → PCWrite=0 in BRANCH; with Lt=0 → PCWrite=1, ResultSrc=00; both retire in 3 cycles.
- jalr → states 0,1,11,10,8; PCWrite=1 only in FETCH and JAL; RegWrite in ALUWB; A=01, B=10 in JAL.
- WAIT_LIMIT=4, mem_ready stuck 0 in FETCH → HALT after 4 cycles, bus_err=1, no further strobes. reset_n=0 for one edge → FETCH, bus_err=0, instret=0.
- op 1111111: with CTRL_ILLEGAL_TRAP_EN → HALT, illegal=1; without → back to FETCH, instret unchanged.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM.
// Sequences each instruction over 3-5 cycles through the shared ALU, the
// unified memory port and the IR/ALUOut/data registers. Includes memory
// wait-state timeout, a retired-instruction counter and sticky error flags.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes into
// HALT and set the sticky illegal flag; otherwise unknown opcodes act as NOPs.
module multicycle_controller #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             LtU,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             bus_err,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UTYPE    = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Wait counter only needs to reach WAIT_LIMIT-1.
  localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  // funct3/funct7b5 to ALU operation; subtract only exists for register ops.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_rtype);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  // Branch condition from the comparator flags; 010/011 are reserved.
  function automatic logic branch_take(input logic [2:0] f3,
                                       input logic       z,
                                       input logic       lt,
                                       input logic       ltu);
    logic take;
    case (f3)
      3'b000:  take = z;
      3'b001:  take = !z;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: take = 1'b0;
    endcase
    return take;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [WC_W-1:0]   w_wait_nxt;
  logic [CNT_W-1:0]  r_instret;
  logic              r_bus_err;
  logic              w_set_bus_err;
  logic              w_is_wait;
  logic              w_tmo;
  logic              w_retire;
  logic              w_mem_req;
  logic              w_mem_write;
  logic              w_adr_src;
  logic              w_ir_write;
  logic              w_pc_write;
  logic              w_reg_write;
  logic [1:0]        w_result_src;
  logic [1:0]        w_alu_src_a;
  logic [1:0]        w_alu_src_b;
  logic [2:0]        w_imm_src;
  logic [3:0]        w_alu_ctl;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic              r_illegal;
  logic              w_set_illegal;
`endif

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                     (r_state == S_MEMWRITE);
  // A completing access on the last allowed cycle takes priority over timeout.
  assign w_tmo     = (WAIT_LIMIT != 0) && (r_wait_cnt == WC_LAST) && !mem_ready;

  // Next-state and control decode; every output defaults to idle/add.
  always_comb begin
    w_next        = r_state;
    w_set_bus_err = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_result_src  = 2'b00;
    w_alu_src_a   = 2'b00;
    w_alu_src_b   = 2'b00;
    w_imm_src     = 3'b000;
    w_alu_ctl     = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_set_illegal = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_alu_src_b  = 2'b10;
          w_result_src = 2'b10;
          w_next       = S_DECODE;
        end else if (w_tmo) begin
          w_next        = S_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI, OP_AUIPC:  w_next = S_UTYPE;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_next        = S_HALT;
            w_set_illegal = 1'b1;
`else
            w_next        = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = op[5] ? IMM_S : IMM_I;
        w_next      = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_tmo) begin
          w_next        = S_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_tmo) begin
          w_next        = S_HALT;
          w_set_bus_err = 1'b1;
        end
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b00;
        w_alu_ctl   = alu_decode(funct3, funct7b5, 1'b1);
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = IMM_I;
        w_alu_ctl   = alu_decode(funct3, funct7b5, 1'b0);
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = 2'b00;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a  = 2'b10;
        w_alu_src_b  = 2'b00;
        w_alu_ctl    = ALU_SUB;
        w_result_src = 2'b00;
        w_pc_write   = branch_take(funct3, Zero, Lt, LtU);
        w_next       = S_FETCH;
      end
      S_JAL: begin
        // PC <- ALUOut (target); ALU forms OldPC+4 for the link write.
        w_pc_write   = 1'b1;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_next       = S_ALUWB;
      end
      S_JALR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_imm_src   = IMM_I;
        w_next      = S_JAL;
      end
      S_UTYPE: begin
        w_alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
        w_alu_src_b = 2'b01;
        w_imm_src   = IMM_U;
        w_next      = S_ALUWB;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Wait counter restarts on any state change and only advances while stalled.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_next != r_state) begin
      w_wait_nxt = '0;
    end else if (w_is_wait && !mem_ready && (WAIT_LIMIT != 0)) begin
      w_wait_nxt = r_wait_cnt + WC_W'(1);
    end
  end

  // An instruction retires when it returns to FETCH; DECODE->FETCH is a NOP.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                    (r_state != S_HALT) && (r_state != S_DECODE);

  // State, wait counter, retired count and sticky bus error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_instret  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
      if (w_set_bus_err) begin
        r_bus_err <= 1'b1;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
    end else if (w_set_illegal) begin
      r_illegal <= 1'b1;
    end
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Write/request strobes are suppressed while reset is held.
  assign mem_req    = reset_n & w_mem_req;
  assign MemWrite   = reset_n & w_mem_write;
  assign IRWrite    = reset_n & w_ir_write;
  assign PCWrite    = reset_n & w_pc_write;
  assign RegWrite   = reset_n & w_reg_write;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign ImmSrc     = w_imm_src;
  assign ALUControl = w_alu_ctl;
  assign state      = r_state;
  assign instret    = r_instret;
  assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (WAIT_LIMIT=4 instance).
// Expectations for the unknown-opcode step follow CTRL_ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

  logic        clk;
  logic        reset_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        Lt;
  logic        LtU;
  logic        mem_ready;
  logic        mem_req;
  logic        MemWrite;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        bus_err;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  int exp_ret;

  multicycle_controller #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .LtU(LtU), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .state(state), .instret(instret),
    .bus_err(bus_err), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000;
    funct7b5 = 1'b0; Zero = 1'b0; Lt = 1'b0; LtU = 1'b0;
    #3;
    chk("rst_memreq_forced", mem_req, 0);
    chk("rst_pcw_forced", PCWrite, 0);
    tick();
    chk("rst_state", state, 0);
    chk("rst_instret", instret, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_illegal", illegal, 0);

    // add x3,x1,x2
    reset_n = 1'b1; #1;
    chk("add_f_irw", IRWrite, 1);
    chk("add_f_pcw", PCWrite, 1);
    chk("add_f_rsrc", ResultSrc, 2);
    chk("add_f_adr", AdrSrc, 0);
    tick(); chk("add_d_state", state, 1); chk("add_d_a", ALUSrcA, 1);
    chk("add_d_imm", ImmSrc, 2);
    tick(); chk("add_x_state", state, 6); chk("add_x_alu", ALUControl, 0);
    tick(); chk("add_wb_state", state, 8); chk("add_wb_regw", RegWrite, 1);
    chk("add_wb_instret", instret, 0);
    tick(); chk("add_ret_state", state, 0); chk("add_instret", instret, 1);

    // addi with bit30 set stays an add
    op = 7'b0010011; funct7b5 = 1'b1;
    tick(); tick(); chk("addi_state", state, 7); chk("addi_alu", ALUControl, 0);
    chk("addi_imm", ImmSrc, 0);
    tick(); tick(); chk("addi_instret", instret, 2);
    funct7b5 = 1'b0;

    // lw with three wait cycles; ready on the last allowed cycle wins
    op = 7'b0000011; funct3 = 3'b010;
    tick(); tick(); chk("lw_adr_state", state, 2); chk("lw_adr_imm", ImmSrc, 0);
    mem_ready = 1'b0;
    tick(); chk("lw_rd1_state", state, 3); chk("lw_rd1_req", mem_req, 1);
    chk("lw_rd1_adr", AdrSrc, 1);
    tick(); chk("lw_rd2_state", state, 3);
    tick(); chk("lw_rd3_state", state, 3); chk("lw_rd3_req", mem_req, 1);
    tick(); mem_ready = 1'b1; #1;
    chk("lw_rd4_state", state, 3); chk("lw_rd4_adr", AdrSrc, 1);
    tick(); chk("lw_wb_state", state, 4); chk("lw_wb_regw", RegWrite, 1);
    chk("lw_wb_rsrc", ResultSrc, 1); chk("lw_bus_err", bus_err, 0);
    tick(); chk("lw_instret", instret, 3);

    // sw
    op = 7'b0100011;
    tick(); tick(); chk("sw_adr_imm", ImmSrc, 1);
    tick(); chk("sw_state", state, 5); chk("sw_memw", MemWrite, 1);
    chk("sw_req", mem_req, 1);
    tick(); chk("sw_instret", instret, 4);

    // bge not taken / taken
    op = 7'b1100011; funct3 = 3'b101; Lt = 1'b1;
    tick(); tick(); chk("bge_nt_state", state, 9); chk("bge_nt_pcw", PCWrite, 0);
    tick(); chk("bge_nt_instret", instret, 5);
    Lt = 1'b0;
    tick(); tick(); chk("bge_t_pcw", PCWrite, 1); chk("bge_t_rsrc", ResultSrc, 0);
    chk("bge_t_alu", ALUControl, 1);
    tick(); chk("bge_t_state", state, 0); chk("bge_t_instret", instret, 6);

    // reserved funct3 never branches
    funct3 = 3'b011; Zero = 1'b1; Lt = 1'b1; LtU = 1'b1;
    tick(); tick(); chk("br011_pcw", PCWrite, 0);
    tick(); chk("br011_instret", instret, 7);
    Zero = 1'b0; Lt = 1'b0; LtU = 1'b0;

    // jalr
    op = 7'b1100111; funct3 = 3'b000; #1;
    chk("jalr_f_pcw", PCWrite, 1);
    tick(); chk("jalr_d_pcw", PCWrite, 0);
    tick(); chk("jalr_state", state, 11); chk("jalr_pcw", PCWrite, 0);
    chk("jalr_a", ALUSrcA, 2);
    tick(); chk("jal_state", state, 10); chk("jal_pcw", PCWrite, 1);
    chk("jal_a", ALUSrcA, 1); chk("jal_b", ALUSrcB, 2);
    tick(); chk("jalr_wb_state", state, 8); chk("jalr_wb_regw", RegWrite, 1);
    chk("jalr_wb_pcw", PCWrite, 0);
    tick(); chk("jalr_instret", instret, 8);

    // lui
    op = 7'b0110111;
    tick(); tick(); chk("lui_state", state, 12); chk("lui_a", ALUSrcA, 3);
    chk("lui_imm", ImmSrc, 4);
    tick(); tick(); chk("lui_instret", instret, 9);

    // unknown opcode
    op = 7'b1111111;
    tick(); chk("ill_d_state", state, 1);
    tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_state", state, 13); chk("ill_flag", illegal, 1);
    chk("ill_instret", instret, 9);
    reset_n = 1'b0;
    tick(); reset_n = 1'b1; #1;
    chk("ill_rst_flag", illegal, 0);
    exp_ret = 0;
`else
    chk("ill_state", state, 0); chk("ill_flag", illegal, 0);
    chk("ill_instret", instret, 9);
    exp_ret = 9;
`endif

    // fetch timeout with WAIT_LIMIT=4
    mem_ready = 1'b0; #1;
    chk("tmo_c1_req", mem_req, 1); chk("tmo_c1_irw", IRWrite, 0);
    tick(); chk("tmo_c2_state", state, 0);
    tick(); chk("tmo_c3_state", state, 0);
    tick(); chk("tmo_c4_state", state, 0); chk("tmo_c4_bus_err", bus_err, 0);
    tick(); chk("tmo_halt_state", state, 13); chk("tmo_bus_err", bus_err, 1);
    chk("tmo_halt_req", mem_req, 0);
    mem_ready = 1'b1;
    tick(); chk("halt_hold_state", state, 13); chk("halt_pcw", PCWrite, 0);
    chk("halt_irw", IRWrite, 0); chk("halt_instret", instret, exp_ret);

    // reset recovery and strobe forcing while reset is held
    reset_n = 1'b0; op = 7'b0110011; funct3 = 3'b000;
    tick(); chk("rec_state", state, 0); chk("rec_bus_err", bus_err, 0);
    chk("rec_instret", instret, 0);
    chk("rec_forced_irw", IRWrite, 0); chk("rec_forced_req", mem_req, 0);
    reset_n = 1'b1; #1;
    chk("rec_irw", IRWrite, 1);

    // reset mid-instruction does not retire it
    tick(); tick(); chk("mid_state", state, 6);
    reset_n = 1'b0;
    tick(); chk("mid_rst_state", state, 0); chk("mid_rst_instret", instret, 0);
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
